// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, multi-cycle controller states and
// datapath select encodings used by the controller, decoder and ALU control.
package mips_pkg;

  // Primary opcodes (IR[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Multi-cycle sequencer states; the encoding is visible on state_o
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // ALU operation classes handed to the ALU decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-operand mux selects
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a request on the memory bus and therefore can stall
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mc_wait_cnt.sv
// Saturating wait counter for memory handshakes; flags a timeout once the
// count reaches TIMEOUT. TIMEOUT = 0 keeps the counter at zero and never
// raises timeout.
module mips_mc_wait_cnt
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wait_cyc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Count stalled request cycles, saturating at the timeout limit
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wait_cyc && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and enables from the current state,
// and stalls on the unified memory's req/ready handshake.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALU_OP_W = 2,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal_op,
  output logic                bus_err,
  output logic [3:0]          state_o
);

  state_t state;
  state_t state_next;
  logic   in_mem;
  logic   timeout;
  logic   wait_cyc;
  logic   cnt_clear;
  logic   bus_err_q;
  logic   known_op;
  logic   unused_alu_zero;

  // The beq decision is made by the datapath (pc_write_cond AND alu_zero);
  // the flag is carried on this port only to keep the interface complete.
  assign unused_alu_zero = alu_zero;

  assign in_mem    = is_mem_state(state);
  assign wait_cyc  = in_mem && !mem_ready && !timeout;
  assign cnt_clear = !in_mem || mem_ready || timeout;

  assign known_op = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                    (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                    (opcode == OP_ADDI)  || (opcode == OP_J);

  mips_mc_wait_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .wait_cyc (wait_cyc),
    .timeout  (timeout)
  );

  // Next-state selection: memory states hold until ready or timeout
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (timeout)        state_next = S_FETCH;
        else if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timeout)        state_next = S_FETCH;
        else if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWR: begin
        if (timeout || mem_ready) state_next = S_FETCH;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // State register and sticky bus-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  // Moore decode of datapath controls; everything is forced low during reset
  // and a timeout withdraws the request and its pending writes.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_OP_W'(ALU_OP_ADD);
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req   = !timeout;
          alu_src_b = SRCB_FOUR;
          pc_src    = PCSRC_ALU;
          ir_write  = mem_ready && !timeout;
          pc_write  = mem_ready && !timeout;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          illegal_op = !known_op;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = !timeout;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = !timeout;
          mem_we  = !timeout;
          iord    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RT;
          alu_op    = ALU_OP_W'(ALU_OP_FUNCT);
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_RT;
          alu_op        = ALU_OP_W'(ALU_OP_SUB);
          pc_write_cond = 1'b1;
          pc_src        = PCSRC_ALUOUT;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign bus_err = bus_err_q && !reset;
  assign state_o = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for the multi-cycle controller: each stimulus cycle
// queues the hand-derived expected state and controls, and a negedge
// monitor pops and compares them against the DUT.
module tb_mips_mc_ctrl;

  localparam int TO = 4;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9;
  localparam logic [3:0] ST_ADDIWB = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       bus_err;
  } ctrl_t;

  typedef struct {
    string      name;
    logic [3:0] st;
    ctrl_t      ctrl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = LW;
  logic       mem_ready = 1'b1;
  logic       alu_zero = 1'b0;

  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, bus_err;
  logic [3:0] state_o;
  ctrl_t      act;

  exp_t sbq[$];
  int   checks = 0;
  int   fails = 0;
  logic expErr = 1'b0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(
    .ALU_OP_W (2),
    .TIMEOUT  (TO),
    .CNT_W    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .alu_zero      (alu_zero),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .illegal_op    (illegal_op),
    .bus_err       (bus_err),
    .state_o       (state_o)
  );

  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                reg_write, illegal_op, bus_err};

  // Expected controls per state, straight from the controller's state table
  function automatic ctrl_t m(logic [3:0] st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'b01; end
      ST_DECODE: c.alu_src_b = 2'b11;
      ST_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
      ST_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      ST_MEMWR:  begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
      ST_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      ST_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
      ST_BRANCH: begin
        c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01;
      end
      ST_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_ADDIWB: c.reg_write = 1;
      ST_JUMP:   begin c.pc_write = 1; c.pc_src = 2'b10; end
      default:   c = '0;
    endcase
    c.bus_err = expErr;
    return c;
  endfunction

  // FETCH with the memory ready: IR and PC both load
  function automatic ctrl_t fr();
    ctrl_t c;
    c = m(ST_FETCH);
    c.ir_write = 1;
    c.pc_write = 1;
    return c;
  endfunction

  task automatic applyStimulus(input string name, input logic rst,
                               input logic [5:0] op, input logic rdy,
                               input logic zero, input logic [3:0] st,
                               input ctrl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    alu_zero  = zero;
    e.name = name;
    e.st   = st;
    e.ctrl = c;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (state_o !== e.st) begin
      fails++;
      $display("[TB] FAIL %s state: got %0d expected %0d", e.name, state_o, e.st);
    end
    checks++;
    if (act !== e.ctrl) begin
      fails++;
      $display("[TB] FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
    end
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    if (sbq.size() > 0) checkOutput(sbq.pop_front());
  end

  initial begin
    ctrl_t c;

    repeat (3) applyStimulus("reset", 1, LW, 1, 0, ST_FETCH, '0);

    applyStimulus("lw_fetch",  0, LW, 1, 0, ST_FETCH,  fr());
    applyStimulus("lw_decode", 0, LW, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("lw_memadr", 0, LW, 1, 0, ST_MEMADR, m(ST_MEMADR));
    applyStimulus("lw_memrd",  0, LW, 1, 0, ST_MEMRD,  m(ST_MEMRD));
    applyStimulus("lw_memwb",  0, LW, 1, 0, ST_MEMWB,  m(ST_MEMWB));

    applyStimulus("sw_fetch",  0, SW, 1, 0, ST_FETCH,  fr());
    applyStimulus("sw_decode", 0, SW, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("sw_memadr", 0, SW, 0, 0, ST_MEMADR, m(ST_MEMADR));
    repeat (3) applyStimulus("sw_wait", 0, SW, 0, 0, ST_MEMWR, m(ST_MEMWR));
    applyStimulus("sw_done",   0, SW, 1, 0, ST_MEMWR,  m(ST_MEMWR));

    applyStimulus("fetch_stall", 0, BEQ, 0, 0, ST_FETCH, m(ST_FETCH));
    applyStimulus("beq1_fetch",  0, BEQ, 1, 1, ST_FETCH,  fr());
    applyStimulus("beq1_decode", 0, BEQ, 1, 1, ST_DECODE, m(ST_DECODE));
    applyStimulus("beq1_branch", 0, BEQ, 1, 1, ST_BRANCH, m(ST_BRANCH));
    applyStimulus("beq0_fetch",  0, BEQ, 1, 0, ST_FETCH,  fr());
    applyStimulus("beq0_decode", 0, BEQ, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("beq0_branch", 0, BEQ, 1, 0, ST_BRANCH, m(ST_BRANCH));

    applyStimulus("r_fetch",  0, RT, 1, 0, ST_FETCH,  fr());
    applyStimulus("r_decode", 0, RT, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("r_exec",   0, RT, 1, 0, ST_EXEC,   m(ST_EXEC));
    applyStimulus("r_aluwb",  0, RT, 1, 0, ST_ALUWB,  m(ST_ALUWB));

    applyStimulus("addi_fetch",  0, ADDI, 1, 0, ST_FETCH,  fr());
    applyStimulus("addi_decode", 0, ADDI, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("addi_ex",     0, ADDI, 1, 0, ST_ADDIEX, m(ST_ADDIEX));
    applyStimulus("addi_wb",     0, ADDI, 1, 0, ST_ADDIWB, m(ST_ADDIWB));

    applyStimulus("j_fetch",  0, JMP, 1, 0, ST_FETCH,  fr());
    applyStimulus("j_decode", 0, JMP, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("j_jump",   0, JMP, 1, 0, ST_JUMP,   m(ST_JUMP));

    applyStimulus("bad_fetch", 0, BAD, 1, 0, ST_FETCH, fr());
    c = m(ST_DECODE);
    c.illegal_op = 1;
    applyStimulus("bad_decode", 0, BAD, 1, 0, ST_DECODE, c);

    applyStimulus("to_fetch",  0, LW, 1, 0, ST_FETCH,  fr());
    applyStimulus("to_decode", 0, LW, 0, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("to_memadr", 0, LW, 0, 0, ST_MEMADR, m(ST_MEMADR));
    repeat (TO) applyStimulus("to_wait", 0, LW, 0, 0, ST_MEMRD, m(ST_MEMRD));
    c = m(ST_MEMRD);
    c.mem_req = 0;
    applyStimulus("to_expire", 0, LW, 0, 0, ST_MEMRD, c);
    expErr = 1'b1;
    applyStimulus("err_fetch",  0, LW, 1, 0, ST_FETCH,  fr());
    applyStimulus("err_decode", 0, LW, 1, 0, ST_DECODE, m(ST_DECODE));
    applyStimulus("abort_reset", 1, LW, 1, 0, ST_MEMADR, '0);
    expErr = 1'b0;
    applyStimulus("rst_fetch",  0, LW, 1, 0, ST_FETCH,  fr());
    applyStimulus("rst_decode", 0, LW, 1, 0, ST_DECODE, m(ST_DECODE));

    for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() > 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
